// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and rst_cause values.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StHold,
        StStage,
        StDone,
        StSoft
    } seq_state_e;

    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_WDOG = 2'b11;

endpackage

// File: rtl/rst_sync2.sv
// Two-flop negedge reset synchronizer: asserts asynchronously, releases on the
// second falling clock edge after rst_ni rises.
module rst_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_sync_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged multi-domain reset sequencer with soft reset and optional watchdog.
// Watchdog is built only when RST_SEQ_WDOG_EN is defined.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM   = 3,
    parameter int unsigned STAGE_DLY = 16,
    parameter int unsigned HOLD_CYC  = 8,
    parameter int unsigned WDOG_CYC  = 1024
) (
    input  logic               clk,
    input  logic               RST_n,
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
    input  logic               wdog_kick,
    output logic [NUM_DOM-1:0] rst_n_dom,
    output logic               seq_done,
    output logic [1:0]         rst_cause
);

    localparam int unsigned StgW  = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned IdxW  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    seq_state_e         state_q, state_d;
    logic [StgW-1:0]    stg_cnt_q, stg_cnt_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               ack_q, ack_d;
    logic [1:0]         cause_q, cause_d;
    logic               rst_sync;
    logic               wdog_fire;

    rst_sync2 u_rst_sync2 (
        .clk_i      (clk),
        .rst_ni     (RST_n),
        .rst_sync_o (rst_sync)
    );

    always_comb begin
        state_d    = state_q;
        stg_cnt_d  = stg_cnt_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        dom_d      = dom_q;
        ack_d      = 1'b0;
        cause_d    = cause_q;
        unique case (state_q)
            StHold: begin
                if (rst_sync) begin
                    // Preload 1: the edge that samples rst_sync counts toward the first stage.
                    state_d   = StStage;
                    stg_cnt_d = StgW'(1);
                    idx_d     = '0;
                end
            end
            StStage: begin
                if (stg_cnt_q == StgW'(STAGE_DLY - 1)) begin
                    stg_cnt_d     = '0;
                    dom_d[idx_q]  = 1'b1;
                    idx_d         = idx_q + 1'b1;
                    if (idx_q == IdxW'(NUM_DOM - 1)) begin
                        state_d = StDone;
                    end
                end else begin
                    stg_cnt_d = stg_cnt_q + 1'b1;
                end
            end
            StDone: begin
                // A soft request wins over a coincident watchdog expiry.
                if (soft_rst_req || wdog_fire) begin
                    state_d    = StSoft;
                    dom_d      = '0;
                    hold_cnt_d = '0;
                    ack_d      = soft_rst_req;
                    cause_d    = soft_rst_req ? CAUSE_SOFT : CAUSE_WDOG;
                end
            end
            StSoft: begin
                if (hold_cnt_q == HoldW'(HOLD_CYC - 1)) begin
                    state_d   = StStage;
                    stg_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StHold;
            stg_cnt_q  <= '0;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            dom_q      <= '0;
            ack_q      <= 1'b0;
            cause_q    <= CAUSE_BTN;
        end else begin
            state_q    <= state_d;
            stg_cnt_q  <= stg_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            idx_q      <= idx_d;
            dom_q      <= dom_d;
            ack_q      <= ack_d;
            cause_q    <= cause_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int unsigned WdogW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;

    // A kick on the expiry edge suppresses the fire.
    assign wdog_fire = (state_q == StDone) && !wdog_kick &&
                       (wdog_cnt_q == WdogW'(WDOG_CYC - 1));

    always_comb begin
        wdog_cnt_d = '0;
        if ((state_q == StDone) && (state_d == StDone) && !wdog_kick) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    logic unused_wdog;

    assign wdog_fire   = 1'b0;
    assign unused_wdog = wdog_kick | (WDOG_CYC == 0);
`endif

    assign rst_n_dom    = dom_q;
    assign seq_done     = (state_q == StDone);
    assign soft_rst_ack = ack_q;
    assign rst_cause    = cause_q;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL provide parameter NUM_DOM, default 3: number of sequenced reset domains (1..8).
REQ-002 SHALL provide parameter STAGE_DLY, default 16: clocks between successive domain releases (>=2).
REQ-003 SHALL provide parameter HOLD_CYC, default 8: clocks all domains are held low after a soft or watchdog reset.
REQ-004 SHALL provide parameter WDOG_CYC, default 1024: watchdog timeout in clocks.
REQ-005 SHALL provide port clk, input, 1: clock; all flops use its negative edge.
REQ-006 SHALL provide port RST_n, input, 1: reset, asynchronous, active-low, raw from the push button.
REQ-007 SHALL provide port soft_rst_req, input, 1: synchronous request to re-run the reset sequence.
REQ-008 SHALL provide port soft_rst_ack, output, 1: one-clock pulse accepting soft_rst_req.
REQ-009 SHALL provide port wdog_kick, input, 1: watchdog service strobe.
REQ-010 SHALL provide port rst_n_dom, output, NUM_DOM: per-domain active-low resets; bit 0 is released first.
REQ-011 SHALL provide port seq_done, output, 1: high while all domains are released.
REQ-012 SHALL provide port rst_cause, output, 2: last reset source: 01 button, 10 soft, 11 watchdog.

Function
REQ-013 SHALL contain a 2-flop negedge synchronizer; the internal rst_sync deasserts on the 2nd negedge after RST_n rises.
REQ-014 SHALL implement FSM states HOLD, STAGE, DONE, SOFT.
REQ-015 In HOLD, the FSM SHALL go to STAGE when rst_sync is high, clearing the stage counter and domain index.
REQ-016 In STAGE, rst_n_dom[i] SHALL rise exactly (i+1)*STAGE_DLY negedges after rst_sync rises, one bit per stage; already-released bits SHALL stay high.
REQ-017 The FSM SHALL enter DONE, and seq_done SHALL assert, on the same edge that rst_n_dom[NUM_DOM-1] rises.
REQ-018 In DONE, soft_rst_req high SHALL, on the next negedge, drive all rst_n_dom low, deassert seq_done, pulse soft_rst_ack for one clock, set rst_cause to 10, and enter SOFT.
REQ-019 Outside DONE, soft_rst_req SHALL be ignored, with no ack and no queuing.
REQ-020 SOFT SHALL last exactly HOLD_CYC clocks, then enter STAGE and re-run REQ-016 timing, counted from the exit of SOFT.
REQ-021 The watchdog counter SHALL run only in DONE; wdog_kick SHALL clear it; reaching WDOG_CYC-1 SHALL act as REQ-018 with rst_cause 11 and no ack.
REQ-022 A kick on the expiry edge SHALL win, so no watchdog reset occurs.
REQ-023 Simultaneous soft_rst_req and watchdog expiry SHALL produce a soft reset (cause 10, ack pulsed).
REQ-024 The counter widths SHALL be sized by clog2 of their parameters, with no wrap before terminal count.

Reset
REQ-025 While RST_n is low, outputs SHALL be asynchronously forced: rst_n_dom all 0, seq_done 0, soft_rst_ack 0, rst_cause 01, FSM HOLD, counters 0.
REQ-026 RST_n asserting mid-sequence, in SOFT, or in DONE SHALL abort immediately and restart from HOLD.
REQ-027 rst_cause SHALL be retained across soft and watchdog resets.

Configuration
REQ-028 The watchdog SHALL be compiled in only when macro RST_SEQ_WDOG_EN is defined.
REQ-029 Without RST_SEQ_WDOG_EN, wdog_kick SHALL remain a port but be ignored, no watchdog counter SHALL exist, and cause 11 SHALL never occur.

Structure
REQ-030 A shared package rst_seq_pkg SHALL hold the FSM state enum and the rst_cause encodings (CAUSE_BTN, CAUSE_SOFT, CAUSE_WDOG).
REQ-031 The synchronizer SHALL be a separate sub-module, rst_sync2, instantiated once.

Verification (NUM_DOM=3, STAGE_DLY=4, HOLD_CYC=8, WDOG_CYC=32)
REQ-032 Release RST_n -> rst_n_dom goes 001, 011, 111 at negedges 6, 10, 14 after the release; seq_done rises at negedge 14; rst_cause=01.
REQ-033 Pulse soft_rst_req in DONE -> next negedge: rst_n_dom=000, ack pulses one clock, cause=10; after 8 clocks, the 4/8/12 staged release follows.
REQ-034 Hold soft_rst_req high during STAGE -> no ack and no timing change; the request is accepted only once DONE is reached.
REQ-035 With the watchdog enabled and no kick -> reset 32 clocks after DONE, cause=11, no ack; kicking every 20 clocks -> no reset.
REQ-036 Assert RST_n low during stage 2 -> all outputs go low asynchronously; on release the full sequence restarts with cause=01.
REQ-037 Same-edge soft_rst_req and watchdog expiry -> cause=10 and ack pulsed; build without the macro -> cause 11 never occurs.
